// File: rtl/rf_arb_pkg.sv
// Shared constants for the register-file write arbiter: default widths,
// requester count and the fixed requester index assignment.
package rf_arb_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned NREQ_DEF   = 3;
  localparam int unsigned STALL_W    = 16;

  // Requester slots within the packed request vectors
  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_MEM = 1;
  localparam int unsigned REQ_IO  = 2;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Request / register-file write bundle between requesters and the arbiter.
// master: requester + register-file side; slave: the arbiter itself.
interface rf_write_arbiter_if import rf_arb_pkg::*; #(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NREQ   = NREQ_DEF
) ();

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   writeOrder;
  logic [ADDR_W-1:0]      writeAddr;
  logic [DATA_W-1:0]      writeData;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, writeOrder, writeAddr, writeData
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, writeOrder, writeAddr, writeData
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational rotating-priority encoder: the search starts at ptr_i and
// wraps modulo NREQ; the first valid bit found becomes the one-hot grant.
// ptr_i is assumed to be below NREQ.
module rr_picker #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned PTR_W = 2
) (
  input  logic [NREQ-1:0]  valid_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  grant_o
);

  logic [NREQ-1:0]   rot;
  logic [NREQ-1:0]   first;
  logic [2*NREQ-1:0] grant_dbl;
  logic              found;

  // Rotate so ptr sits at bit 0, pick lowest set bit, rotate back
  always_comb begin
    rot   = NREQ'({valid_i, valid_i} >> ptr_i);
    first = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        first[k] = 1'b1;
        found    = 1'b1;
      end
    end
    grant_dbl = {{NREQ{1'b0}}, first} << ptr_i;
    grant_o   = grant_dbl[NREQ-1:0] | grant_dbl[2*NREQ-1:NREQ];
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter funnelling NREQ register-file write requests into one
// write port, one write per cycle, write issued the cycle after acceptance.
// Optional macro RF_R0_ZERO_EN: writes to address 0 are accepted but dropped
// (register 0 reads as a constant zero in that build).
module rf_write_arbiter import rf_arb_pkg::*; #(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NREQ   = NREQ_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               freeze,
  rf_write_arbiter_if.slave  bus,
  output logic [STALL_W-1:0] stall_cycles
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = $clog2(NREQ + 1);
  localparam int unsigned SumW = STALL_W + 1;

  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]    valid_eff, grant;
  logic               accept;
  logic [PtrW-1:0]    winner;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [CntW-1:0]    n_stalled;
  logic [SumW-1:0]    stall_sum;
  logic [STALL_W-1:0] stall_q, stall_d;

  // Nothing may be granted while frozen or in reset
  assign valid_eff = (freeze || reset) ? '0 : bus.req_valid;

  rr_picker #(
    .NREQ  (NREQ),
    .PTR_W (PtrW)
  ) u_picker (
    .valid_i (valid_eff),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  assign bus.req_ready = grant;
  assign accept        = |grant;

  // Mux out the winning requester's index, address and data
  always_comb begin
    winner   = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        winner   = PtrW'(i);
        sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next pointer and write-port state; address/data hold when idle
  always_comb begin
    ptr_d  = ptr_q;
    addr_d = addr_q;
    data_d = data_q;
    wr_d   = 1'b0;
    if (accept) begin
      ptr_d  = (winner == PtrW'(NREQ - 1)) ? '0 : winner + PtrW'(1);
      addr_d = sel_addr;
      data_d = sel_data;
`ifdef RF_R0_ZERO_EN
      wr_d   = (sel_addr != '0);
`else
      wr_d   = 1'b1;
`endif
    end
  end

  // Saturating accumulation of valid-but-not-granted requesters
  always_comb begin
    n_stalled = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      n_stalled = n_stalled + CntW'(bus.req_valid[i] & ~grant[i]);
    end
    stall_sum = {1'b0, stall_q} + SumW'(n_stalled);
    stall_d   = stall_sum[STALL_W] ? '1 : stall_sum[STALL_W-1:0];
  end

  // State update with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      stall_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      stall_q <= stall_d;
    end
  end

  // A pending write is squashed if reset arrives in its output cycle
  assign bus.writeOrder = wr_q & ~reset;
  assign bus.writeAddr  = addr_q;
  assign bus.writeData  = data_q;
  assign stall_cycles   = stall_q;

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16: register data width.
REQ-002 SHALL have parameter ADDR_W, default 3: register address width (8 registers).
REQ-003 SHALL have parameter NREQ, default 3: requester count (0=ALU, 1=MEM, 2=IO).
REQ-004 SHALL have port clock  in  1: single clock; all state updates on posedge.
REQ-005 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-006 SHALL have port freeze  in  1: when high, no grant is issued.
REQ-007 SHALL have port req_valid  in  NREQ: per-requester write request.
REQ-008 SHALL have port req_addr  in  NREQ*ADDR_W: packed target addresses, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port req_data  in  NREQ*DATA_W: packed write data, same packing rule.
REQ-010 SHALL have port req_ready  out  NREQ: one-hot grant; request i accepted at a posedge where req_valid[i] and req_ready[i] are both high.
REQ-011 SHALL have port writeOrder  out  1: register-file write enable.
REQ-012 SHALL have port writeAddr  out  ADDR_W: register-file write address.
REQ-013 SHALL have port writeData  out  DATA_W: register-file write data.
REQ-014 SHALL have port stall_cycles  out  16: saturating count of lost-arbitration cycles.

Function
REQ-015 SHALL drive req_ready combinationally: at most one bit high; none when freeze=1, reset=1 or req_valid=0.
REQ-016 SHALL arbitrate round-robin: priority search starts at pointer ptr and wraps modulo NREQ; the first valid requester wins.
REQ-017 SHALL set ptr to (winner+1) mod NREQ on each accepted request; ptr SHALL hold when nothing is accepted.
REQ-018 SHALL bound the wait of any continuously valid requester to NREQ-1 grants to others, provided freeze is low.
REQ-019 SHALL register the accepted addr and data. writeOrder SHALL be high for exactly the one cycle after acceptance (latency 1), so the register file writes on the following negedge.
REQ-020 SHALL drive writeOrder=0 in any cycle following no acceptance; writeAddr and writeData SHALL hold their last values.
REQ-021 SHALL accept back-to-back requests in consecutive cycles; throughput is 1 write per cycle.
REQ-022 SHALL serialise same-address requests in the same cycle in round-robin order; the later grant's data is the final register content.
REQ-023 SHALL require requesters to hold addr and data stable while valid and not ready; the arbiter SHALL NOT check this.
REQ-024 SHALL increment stall_cycles by the number of valid, ungranted requesters each cycle (freeze included), saturating at 16'hFFFF.

Reset
REQ-025 SHALL, with reset high at a posedge, set ptr=0, writeOrder=0, writeAddr=0, writeData=0 and stall_cycles=0.
REQ-026 SHALL NOT produce a write for a request presented during reset; that request SHALL be arbitrated afresh after reset deasserts.
REQ-027 SHALL drop a write already accepted before reset if reset is high in its output cycle: writeOrder is forced to 0.

Configuration
REQ-028 SHALL support macro RF_R0_ZERO_EN. When defined, requests to address 0 are accepted normally but writeOrder stays 0 in the output cycle. When undefined, address 0 is written like any other address.

Structure
REQ-029 SHALL take DATA_W, ADDR_W, NREQ defaults and requester index constants (REQ_ALU, REQ_MEM, REQ_IO) from shared package rf_arb_pkg.
REQ-030 SHALL put the combinational rotating-priority encoder in sub-module rr_picker (inputs valid vector and ptr; output one-hot grant).

Verification
REQ-031 SHALL cover: valid=3'b111 held 6 cycles with ptr=0 -> grants ALU,MEM,IO,ALU,MEM,IO; writeOrder high cycles 2-7.
REQ-032 SHALL cover: MEM writes addr 5, data 16'hBEEF -> one cycle later writeOrder=1, writeAddr=5, writeData=16'hBEEF, then writeOrder=0.
REQ-033 SHALL cover: freeze=1 for 4 cycles with valid=3'b011 -> no ready; stall_cycles=8; ALU granted in the first cycle after freeze drops.
REQ-034 SHALL cover: ALU and IO both target addr 2 in the same cycle with data 1 and 3 -> two writes in order ALU then IO; final data 3.
REQ-035 SHALL cover: reset asserted in the cycle after an acceptance -> writeOrder=0, ptr=0, stall_cycles=0.
REQ-036 SHALL cover: with RF_R0_ZERO_EN, IO writes addr 0 -> req_ready pulses, writeOrder remains 0; without the macro, writeOrder=1.
